// File: rtl/tank_control.sv
// Keyboard make/break events to per-player tank direction, moving flag and
// rate-limited auto-repeating fire pulse. One tank_player instance per player.

module tank_player #(
  parameter int PID         = 0,
  parameter int FIRE_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid_i,
  input  logic [7:0] ascii_i,
  input  logic       key_release_i,
  output logic [2:0] dir_o,
  output logic       moving_o,
  output logic       fire_o
);
  localparam int CW = (FIRE_PERIOD > 2) ? $clog2(FIRE_PERIOD) : 1;
  localparam logic [CW-1:0] FP_M1 = CW'(FIRE_PERIOD - 1);

  localparam logic [7:0] K_LEFT  = (PID == 0) ? 8'h61 : 8'h6A;
  localparam logic [7:0] K_RIGHT = (PID == 0) ? 8'h64 : 8'h6C;
  localparam logic [7:0] K_UP    = (PID == 0) ? 8'h77 : 8'h69;
  localparam logic [7:0] K_DOWN  = (PID == 0) ? 8'h73 : 8'h6B;
  localparam logic [7:0] K_FIRE  = (PID == 0) ? 8'h20 : 8'h0D;

  logic [3:0]    held_q, held_d;
  logic [2:0]    dir_q, dir_d;
  logic          fire_held_q, fire_held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire_q, fire_d;

  logic       dir_hit;
  logic [1:0] dsel;
  logic       make, brk, dir_mk, dir_bk, fire_mk, fire_bk, cnt_zero;
  logic [3:0] dmask, remain;

  always_comb begin
    dir_hit = 1'b1;
    dsel    = 2'd0;
    case (ascii_i)
      K_LEFT:  dsel = 2'd0;
      K_RIGHT: dsel = 2'd1;
      K_UP:    dsel = 2'd2;
      K_DOWN:  dsel = 2'd3;
      default: dir_hit = 1'b0;
    endcase
  end

  assign make     = key_valid_i & ~key_release_i;
  assign brk      = key_valid_i &  key_release_i;
  assign dir_mk   = make & dir_hit;
  assign dir_bk   = brk  & dir_hit;
  assign fire_mk  = make & (ascii_i == K_FIRE);
  assign fire_bk  = brk  & (ascii_i == K_FIRE);
  assign cnt_zero = (cnt_q == '0);
  assign dmask    = 4'b0001 << dsel;
  assign remain   = held_q & ~dmask;

  // Releasing the facing key falls back to the highest-priority key still held.
  always_comb begin
    held_d = held_q;
    dir_d  = dir_q;
    if (dir_mk) begin
      held_d = held_q | dmask;
      dir_d  = {1'b0, dsel};
    end else if (dir_bk) begin
      held_d = remain;
      if (dir_q == {1'b0, dsel} && |remain) begin
        if (remain[0])      dir_d = 3'd0;
        else if (remain[1]) dir_d = 3'd1;
        else if (remain[2]) dir_d = 3'd2;
        else                dir_d = 3'd3;
      end
    end
  end

  // Pulse whenever fire is wanted and the cooldown has expired; a break wins.
  always_comb begin
    fire_held_d = fire_held_q;
    fire_d      = 1'b0;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
    if (fire_bk) begin
      fire_held_d = 1'b0;
    end else if ((fire_mk || fire_held_q) && cnt_zero) begin
      fire_d      = 1'b1;
      fire_held_d = 1'b1;
      cnt_d       = FP_M1;
    end else if (fire_mk) begin
      fire_held_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= '0;
      dir_q       <= 3'd1;
      fire_held_q <= 1'b0;
      cnt_q       <= '0;
      fire_q      <= 1'b0;
    end else begin
      held_q      <= held_d;
      dir_q       <= dir_d;
      fire_held_q <= fire_held_d;
      cnt_q       <= cnt_d;
      fire_q      <= fire_d;
    end
  end

  assign dir_o    = dir_q;
  assign moving_o = |held_q;
  assign fire_o   = fire_q;
endmodule

module tank_control #(
  parameter int PLAYERS     = 2,
  parameter int FIRE_PERIOD = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [7:0]           ascii,
  input  logic                 key_release,
  output logic [3*PLAYERS-1:0] direct,
  output logic [PLAYERS-1:0]   moving,
  output logic [PLAYERS-1:0]   fire
);
  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    tank_player #(.PID(p), .FIRE_PERIOD(FIRE_PERIOD)) u_pl (
      .clk          (clk),
      .rst          (rst),
      .key_valid_i  (key_valid),
      .ascii_i      (ascii),
      .key_release_i(key_release),
      .dir_o        (direct[3*p +: 3]),
      .moving_o     (moving[p]),
      .fire_o       (fire[p])
    );
  end
endmodule

// File: tb/tb_tank_control.sv
// Bench for tank_control (2 players, FIRE_PERIOD=4) against an event-level model.

module tb_tank_control;
  localparam int FP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       key_release = 1'b0;
  logic [5:0] direct;
  logic [1:0] moving;
  logic [1:0] fire;

  int errors = 0;
  int checks = 0;

  tank_control #(.PLAYERS(2), .FIRE_PERIOD(FP)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .ascii(ascii),
    .key_release(key_release), .direct(direct), .moving(moving), .fire(fire)
  );

  always #5 clk = ~clk;

  // Model: held keys as sets, fire ready when FP edges passed since last shot.
  bit [3:0]  m_held [2];
  int        m_dir  [2];
  bit        m_fh   [2];
  longint    m_last [2];
  bit        m_fire [2];
  longint    ecount = 0;

  function automatic int kmap(input int p, input logic [7:0] a);
    logic [7:0] codes [5];
    if (p == 0) codes = '{8'h61, 8'h64, 8'h77, 8'h73, 8'h20};
    else        codes = '{8'h6A, 8'h6C, 8'h69, 8'h6B, 8'h0D};
    for (int i = 0; i < 5; i++) if (codes[i] == a) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_held[p] = '0; m_dir[p] = 1; m_fh[p] = 0; m_last[p] = -1000; m_fire[p] = 0;
    end
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] a, input bit r);
    for (int p = 0; p < 2; p++) begin
      int k = kmap(p, a);
      bit mk = v && !r;
      bit bk = v && r;
      bit fm = mk && (k == 4);
      bit fb = bk && (k == 4);
      bit ready = (ecount - m_last[p]) >= FP;
      if (k >= 0 && k < 4) begin
        if (mk) begin
          m_held[p][k] = 1'b1; m_dir[p] = k;
        end else if (bk) begin
          m_held[p][k] = 1'b0;
          if (m_dir[p] == k && m_held[p] != 0)
            for (int i = 3; i >= 0; i--) if (m_held[p][i]) m_dir[p] = i;
        end
      end
      m_fire[p] = !fb && (fm || m_fh[p]) && ready;
      if (m_fire[p]) m_last[p] = ecount;
      if (fm) m_fh[p] = 1'b1;
      if (fb) m_fh[p] = 1'b0;
    end
    ecount++;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_dir[1][2:0], m_dir[0][2:0], |m_held[1], |m_held[0], m_fire[1], m_fire[0]};
  endfunction

  task automatic tick(input bit v, input logic [7:0] a, input bit r);
    key_valid = v; ascii = a; key_release = r;
    @(posedge clk);
    model_step(v, a, r);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({direct, moving, fire} !== 10'b001001_00_00) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", {direct, moving, fire}, 10'b001001_00_00);
    end
    tick(1, 8'h7A, 0);
    tick(1, 8'h7A, 1);
    checks++;
    if ({direct, moving, fire} !== 10'b001001_00_00) begin
      errors++;
      $display("FAIL unmapped got=%b want=%b", {direct, moving, fire}, 10'b001001_00_00);
    end
  endtask

  task automatic test_direction();
    logic [7:0] a [5] = '{8'h77, 8'h61, 8'h61, 8'h77, 8'h00};
    bit         r [5] = '{0, 0, 1, 1, 0};
    logic [3:0] want [5] = '{4'b010_1, 4'b000_1, 4'b010_1, 4'b010_0, 4'b010_0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(i < 4, a[i], r[i]);
      checks++;
      if ({direct[2:0], moving[0]} !== want[i] || {direct, moving, fire} !== exp_vec()) begin
        errors++;
        $display("FAIL dir_basic step%0d got=%b want=%b model=%b", i,
                 {direct[2:0], moving[0]}, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick(1, 8'h73, 0); tick(1, 8'h64, 0); tick(1, 8'h61, 0);
    checks++;
    if (direct[2:0] !== 3'b000) begin
      errors++; $display("FAIL prio_last got=%b want=000", direct[2:0]);
    end
    tick(1, 8'h61, 1);
    checks++;
    if (direct[2:0] !== 3'b001 || moving[0] !== 1'b1) begin
      errors++; $display("FAIL prio_right got=%b want=001", direct[2:0]);
    end
    tick(1, 8'h64, 1);
    checks++;
    if (direct[2:0] !== 3'b011) begin
      errors++; $display("FAIL prio_down got=%b want=011", direct[2:0]);
    end
    tick(1, 8'h61, 1);
    checks++;
    if ({direct, moving, fire} !== exp_vec() || direct[2:0] !== 3'b011) begin
      errors++; $display("FAIL prio_unheld got=%b want=%b", {direct, moving, fire}, exp_vec());
    end
  endtask

  task automatic test_fire_timing();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bit want;
      if (c == 0 || c == 11) tick(1, 8'h20, 0);
      else if (c == 10)      tick(1, 8'h20, 1);
      else                   tick(0, 8'h00, 0);
      want = (c + 1 == 1) || (c + 1 == 5) || (c + 1 == 9) || (c + 1 == 13);
      checks++;
      if (fire[0] !== want || {direct, moving, fire} !== exp_vec()) begin
        errors++;
        $display("FAIL fire_timing cycle%0d got=%b want=%b", c + 1, fire[0], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last1 = -1;
    do_reset();
    tick(1, 8'h61, 0);
    tick(1, 8'h6C, 0);
    tick(1, 8'h20, 0);
    for (int c = 0; c < 14; c++) begin
      tick(1, 8'h0D, 0);
      checks++;
      if ({direct, moving, fire} !== exp_vec()) begin
        errors++;
        $display("FAIL two_player c%0d got=%b want=%b", c, {direct, moving, fire}, exp_vec());
      end
      if (fire[1] === 1'b1) begin
        if (last1 >= 0) begin
          checks++;
          if (c - last1 != FP) begin
            errors++; $display("FAIL p1_spacing got=%0d want=%0d", c - last1, FP);
          end
        end
        last1 = c;
      end
    end
    checks++;
    if (direct !== 6'b001_000) begin
      errors++; $display("FAIL two_player_dir got=%b want=001000", direct);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1, 8'h77, 0);
    tick(1, 8'h20, 0);
    repeat (6) tick(0, 8'h00, 0);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({direct, moving, fire} !== 10'b001001_00_00) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b", {direct, moving, fire}, 10'b001001_00_00);
    end
    rst = 1'b0;
    model_reset();
    tick(1, 8'h77, 1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({direct, moving, fire} !== 10'b001001_00_00 || exp_vec() !== 10'b001001_00_00) begin
        errors++;
        $display("FAIL reset_after c%0d got=%b want=%b", c, {direct, moving, fire}, 10'b001001_00_00);
      end
      tick(0, 8'h00, 0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'h61, 8'h64, 8'h77, 8'h73, 8'h20,
                              8'h6A, 8'h6C, 8'h69, 8'h6B, 8'h0D, 8'h7A, 8'h00};
    do_reset();
    for (int c = 0; c < 500; c++) begin
      tick($urandom_range(9, 0) < 6, pool[$urandom_range(11, 0)], $urandom_range(2, 0) == 0);
      checks++;
      if ({direct, moving, fire} !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d got=%b want=%b", c, {direct, moving, fire}, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direction();
    test_priority();
    test_fire_timing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tank_control.md
# tank_control

Multi-player keyboard-to-tank control decoder. Consumes decoded key make/break events from the keyboard front end and maintains, per player, the set of held keys, the tank facing direction with last-pressed priority, a moving flag, and a rate-limited auto-repeating fire pulse. It sits between the keyboard ASCII decoder and the tank movement / bullet spawning logic, and supports one or two players on one keyboard.

## Interface
- PLAYERS, 2, number of players; legal values 1 or 2.
- FIRE_PERIOD, 25_000_000, minimum cycles between fire pulses of one player and auto-repeat interval while fire is held; ≥ 2.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- key_valid  input  1  one-cycle strobe: a key event is present on ascii/key_release.
- ascii  input  8  ASCII code of the event key.
- key_release  input  1  0 = make (press), 1 = break (release); sampled with key_valid.
- direct  output  3*PLAYERS  per-player direction, player p at [3p+2:3p]; LEFT=000, RIGHT=001, UP=010, DOWN=011.
- moving  output  PLAYERS  bit p high while player p holds any direction key.
- fire  output  PLAYERS  bit p one-cycle pulse: player p fires.

## Operation
- Key map, fixed: player 0: 'a' 0x61 LEFT, 'd' 0x64 RIGHT, 'w' 0x77 UP, 's' 0x73 DOWN, space 0x20 FIRE. Player 1: 'j' 0x6A LEFT, 'l' 0x6C RIGHT, 'i' 0x69 UP, 'k' 0x6B DOWN, enter 0x0D FIRE. Player 1 keys ignored when PLAYERS=1.
- Unmapped codes, and cycles with key_valid=0: no state change.
- Per player state: held[3:0] (one bit per direction), last_dir[2:0], fire_held, cooldown counter cnt of width $clog2(FIRE_PERIOD).
- Direction make: set held bit; last_dir <= that direction (also on typematic repeat of an already-held key).
- Direction break: clear held bit. If the released key equals last_dir and other direction keys remain held, last_dir <= highest-priority remaining key, priority LEFT > RIGHT > UP > DOWN. If no keys remain, last_dir unchanged (tank keeps facing).
- Break of a key not held: clear (no-op), last_dir unchanged.
- direct = last_dir register; moving = |held register.
- Fire, per player, evaluated every cycle:
  - cnt ≠ 0: cnt decrements by 1.
  - Fire make while cnt = 0 and fire_held = 0: fire pulse next cycle, cnt <= FIRE_PERIOD-1, fire_held <= 1.
  - Fire make while cnt ≠ 0: fire_held <= 1, no pulse yet.
  - fire_held = 1 and cnt = 0 (no break this cycle): pulse, cnt <= FIRE_PERIOD-1 (auto-repeat; also serves press during cooldown).
  - Typematic repeat make while fire_held = 1: no effect, does not restart cnt.
  - Fire break: fire_held <= 0; cnt keeps counting; no further pulses.
  - Break and cnt = 0 in same cycle: no pulse.
- Pulses never closer than FIRE_PERIOD cycles per player. Players fully independent.

## Timing
- All outputs registered; event on key_valid at edge n is visible on direct/moving/fire after edge n (1-cycle latency).
- fire is high for exactly one cycle per shot.
- Only one event per cycle by interface contract; player states update independently in the same cycle (e.g. P0 cnt expiry coincident with a P1 event).
- Reset (asynchronous assert, any time including mid-cooldown or with keys held): held=0, last_dir=RIGHT (001), fire_held=0, cnt=0; outputs direct=all players 001, moving=0, fire=0. Keys held across reset are treated as released; a subsequent break is a no-op.

## Test plan
- Reset then idle: direct=6'b001_001, moving=2'b00, fire=2'b00; unmapped 0x7A make/break -> no change.
- P0 make 'w' -> next cycle direct[2:0]=010, moving[0]=1; make 'a' -> 000; break 'a' -> 010 (UP still held); break 'w' -> moving[0]=0, direct[2:0] stays 010.
- P0 hold 's','d','a', last pressed 'a'; break 'a' -> RIGHT (001) by priority; break 'd' -> DOWN (011).
- FIRE_PERIOD=4: make space at cycle 0 -> fire[0] pulses at 1, 5, 9; break at cycle 10 -> no more pulses; make at cycle 11 -> pulse at 13 (cnt expiry), not 12.
- FIRE_PERIOD=4: P0 and P1 fire concurrently, P1 typematic repeats of enter every cycle -> P1 pulses still spaced exactly 4; P0 direction 'a' and P1 direction 'l' independent (direct=6'b001_000).
- Assert rst mid-auto-repeat with 'w' and space held -> immediate reset values; break 'w' after reset -> no change.
